// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the future receiver.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity_type encodings (2'b11 also means none)
//   tx_state_t                    : transmit FSM states with fixed encodings
//   parity_enabled()              : true when a parity bit follows the data bits
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO buffering words for the UART transmitter.
//   clk, reset      : clock, asynchronous active-low reset (flushes pointers/count)
//   push, push_data : write request; ignored while full
//   pop, pop_data   : read request; pop_data shows the oldest word (ignored while empty)
//   count           : words held, 0..FIFO_DEPTH
//   full, empty     : occupancy flags decoded from count
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; the flushed pointers/count make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so a power-of-two depth wraps for free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with an input FIFO.
//   clk, reset   : clock, asynchronous active-low reset (aborts any frame)
//   data_in      : word to send, LSB first; pushed when data_valid && data_ready
//   data_valid   : push request
//   data_ready   : FIFO not full (decoded from the registered count)
//   parity_type  : 00 none, 01 odd, 10 even, 11 none; latched at frame load
//   stop_two     : 0 one stop bit, 1 two stop bits; latched at frame load
//   baud_div     : clk cycles per bit (0 acts as 1); latched at frame load
//   data_tx      : serial line, idle high
//   active_flag  : high while a frame is on the line
//   done_flag    : one-cycle pulse on the last cycle boundary of each frame
//   fifo_count   : words currently buffered
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [1:0]                    parity_type,
    input  logic                          stop_two,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          data_tx,
    output logic                          active_flag,
    output logic                          done_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    tx_state_t         state;
    logic [DIV_W-1:0]  baud_cnt;
    logic [DIV_W-1:0]  div_l;
    logic              par_en_l;
    logic              par_bit_l;
    logic              stop_two_l;
    logic [DATA_W-1:0] shift;
    logic [IW-1:0]     bit_idx;
    logic              stop_idx;

    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_end;
    logic              last_stop;
    logic              load;
    logic [DIV_W-1:0]  div_eff;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (load),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_ready = !fifo_full;
    assign div_eff    = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign bit_end    = (state != IDLE) && (baud_cnt == div_l - 1'b1);
    assign last_stop  = (state == STOP) && bit_end && (stop_idx == stop_two_l);
    // A new frame loads from IDLE or straight out of the final stop bit, so
    // queued words go out with no idle bit between frames.
    assign load       = !fifo_empty && ((state == IDLE) || last_stop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            div_l       <= DIV_W'(1);
            par_en_l    <= 1'b0;
            par_bit_l   <= 1'b0;
            stop_two_l  <= 1'b0;
            shift       <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            data_tx     <= 1'b1;
            active_flag <= 1'b0;
            done_flag   <= 1'b0;
        end else begin
            done_flag <= last_stop;

            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (load) begin
                shift       <= fifo_data;
                div_l       <= div_eff;
                par_en_l    <= parity_enabled(parity_type);
                // Even parity is the data XOR; odd is its inverse.
                par_bit_l   <= (^fifo_data) ^ (parity_type == PAR_ODD);
                stop_two_l  <= stop_two;
                bit_idx     <= '0;
                stop_idx    <= 1'b0;
                state       <= START;
                data_tx     <= 1'b0;
                active_flag <= 1'b1;
            end else begin
                case (state)
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            data_tx <= shift[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == LAST_BIT) begin
                                if (par_en_l) begin
                                    state   <= PARITY;
                                    data_tx <= par_bit_l;
                                end else begin
                                    state    <= STOP;
                                    stop_idx <= 1'b0;
                                    data_tx  <= 1'b1;
                                end
                            end else begin
                                shift   <= shift >> 1;
                                bit_idx <= bit_idx + 1'b1;
                                data_tx <= shift[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state    <= STOP;
                            stop_idx <= 1'b0;
                            data_tx  <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            if (stop_idx == stop_two_l) begin
                                state       <= IDLE;
                                data_tx     <= 1'b1;
                                active_flag <= 1'b0;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        data_tx <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
